// File: rtl/frame_ram_pkg.sv
// Shared constants and state encoding for the 128x64 mono frame RAM arbiter.
package frame_ram_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 11;
    localparam int DEFAULT_DEPTH      = 1024;
    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int OLED_COLUMNS       = 128;
    localparam int OLED_PAGES         = 8;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;

endpackage

// File: rtl/frame_ram_read_pipe.sv
// Two-stage valid/out-of-range tracker that returns VGA read data two edges after the request.
module frame_ram_read_pipe
    import frame_ram_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  request,
    input  logic                  out_of_range,
    input  logic [DATA_WIDTH-1:0] read_data,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid
);

    logic [1:0] valid_sr;
    logic [1:0] oor_sr;

    // RAM data for a request at edge k is on read_data during the cycle after edge k+1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_sr <= '0;
            oor_sr   <= '0;
            valid    <= 1'b0;
            data     <= '0;
        end else begin
            valid_sr <= {valid_sr[0], request};
            oor_sr   <= {oor_sr[0], out_of_range};
            valid    <= valid_sr[1];
            data     <= (valid_sr[1] && !oor_sr[1]) ? read_data : '0;
        end
    end

endmodule

// File: rtl/frame_ram_arbiter.sv
// Single-port frame RAM arbiter: VGA read > fill write > host write, one access per clock.
module frame_ram_arbiter
    import frame_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  vga_request,
    input  logic [ADDR_WIDTH-1:0] vga_address,
    output logic [DATA_WIDTH-1:0] vga_data,
    output logic                  vga_valid,
    input  logic                  host_valid,
    input  logic [ADDR_WIDTH-1:0] host_address,
    input  logic [DATA_WIDTH-1:0] host_data,
    output logic                  host_ready,
    input  logic                  fill_start,
    input  logic [DATA_WIDTH-1:0] fill_pattern,
    output logic                  fill_busy,
    output logic                  fill_done,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_write_data,
    output logic                  ram_write_enable,
    input  logic [DATA_WIDTH-1:0] ram_read_data
);

    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_A  = ADDR_WIDTH'(DEPTH - 1);

    fill_state_t           state, state_next;
    logic [ADDR_WIDTH-1:0] count, count_next;
    logic [DATA_WIDTH-1:0] pattern, pattern_next;
    logic [ADDR_WIDTH-1:0] address_next;
    logic [DATA_WIDTH-1:0] wdata_next;
    logic                  we_next;
    logic                  busy_next;
    logic                  done_next;

    assign host_ready = !rst && !vga_request && (state == IDLE) && !fill_start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            count            <= '0;
            pattern          <= '0;
            ram_address      <= '0;
            ram_write_data   <= '0;
            ram_write_enable <= 1'b0;
            fill_busy        <= 1'b0;
            fill_done        <= 1'b0;
        end else begin
            state            <= state_next;
            count            <= count_next;
            pattern          <= pattern_next;
            ram_address      <= address_next;
            ram_write_data   <= wdata_next;
            ram_write_enable <= we_next;
            fill_busy        <= busy_next;
            fill_done        <= done_next;
        end
    end

    always_comb begin
        state_next   = state;
        count_next   = count;
        pattern_next = pattern;
        address_next = ram_address;
        wdata_next   = ram_write_data;
        we_next      = 1'b0;
        busy_next    = fill_busy;
        done_next    = 1'b0;

        if (vga_request) begin
            address_next = vga_address;
        end

        case (state)
            IDLE: begin
                if (fill_start) begin
                    state_next   = FILL;
                    pattern_next = fill_pattern;
                    count_next   = '0;
                    busy_next    = 1'b1;
                end else if (host_valid && host_ready && (host_address < DEPTH_A)) begin
                    // Out-of-range host writes complete the handshake but never touch the RAM.
                    address_next = host_address;
                    wdata_next   = host_data;
                    we_next      = 1'b1;
                end
            end
            FILL: begin
                if (!vga_request) begin
                    address_next = count;
                    wdata_next   = pattern;
                    we_next      = 1'b1;
                    if (count == LAST_A) begin
                        state_next = IDLE;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                    end else begin
                        count_next = count + ADDR_WIDTH'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    frame_ram_read_pipe #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_read_pipe (
        .clk         (clk),
        .rst         (rst),
        .request     (vga_request),
        .out_of_range(vga_address >= DEPTH_A),
        .read_data   (ram_read_data),
        .data        (vga_data),
        .valid       (vga_valid)
    );

endmodule

// File: tb/tb_frame_ram_arbiter.sv
// Directed and randomized checks of frame_ram_arbiter against a memory-level reference model.
module tb_frame_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vga_request = 1'b0;
    logic [10:0] vga_address = '0;
    logic [7:0]  vga_data;
    logic        vga_valid;
    logic        host_valid = 1'b0;
    logic [10:0] host_address = '0;
    logic [7:0]  host_data = '0;
    logic        host_ready;
    logic        fill_start = 1'b0;
    logic [7:0]  fill_pattern = '0;
    logic        fill_busy;
    logic        fill_done;
    logic [10:0] ram_address;
    logic [7:0]  ram_write_data;
    logic        ram_write_enable;
    logic [7:0]  ram_read_data;

    frame_ram_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .vga_request     (vga_request),
        .vga_address     (vga_address),
        .vga_data        (vga_data),
        .vga_valid       (vga_valid),
        .host_valid      (host_valid),
        .host_address    (host_address),
        .host_data       (host_data),
        .host_ready      (host_ready),
        .fill_start      (fill_start),
        .fill_pattern    (fill_pattern),
        .fill_busy       (fill_busy),
        .fill_done       (fill_done),
        .ram_address     (ram_address),
        .ram_write_data  (ram_write_data),
        .ram_write_enable(ram_write_enable),
        .ram_read_data   (ram_read_data)
    );

    always #5 clk = ~clk;

    // Single-port synchronous-read RAM attached to the arbiter.
    logic       do_preload = 1'b1;
    logic [7:0] ram_mem [1024];
    always @(posedge clk) begin
        if (do_preload) begin
            for (int i = 0; i < 1024; i++) ram_mem[i] <= 8'(i) ^ 8'hA5;
        end else if (ram_write_enable && ram_address < 11'd1024) begin
            ram_mem[ram_address[9:0]] <= ram_write_data;
        end
        ram_read_data <= ram_mem[ram_address[9:0]];
    end

    // Reference model: memory contents plus fill progress in plain integers.
    logic [7:0] model_mem [1024];
    bit         m_filling;
    int         m_fill_next;
    logic [7:0] m_pattern;
    logic       h1_v, h2_v;
    logic [7:0] h1_d, h2_d;

    int n_assert = 0;
    int n_fail = 0;
    int write_count, busy_count, done_count;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic        exp_ready, wr, done_exp, cur_v;
        logic [10:0] wa;
        logic [7:0]  wd, cur_d;
        #1;
        exp_ready = !vga_request && !m_filling && !fill_start;
        check("host_ready", host_ready, exp_ready);
        cur_v = vga_request;
        cur_d = (vga_address >= 11'd1024) ? 8'h00 : model_mem[vga_address[9:0]];
        wr = 1'b0; done_exp = 1'b0; wa = '0; wd = '0;
        if (!m_filling) begin
            if (fill_start) begin
                m_filling = 1'b1; m_fill_next = 0; m_pattern = fill_pattern;
            end else if (host_valid && exp_ready && host_address < 11'd1024) begin
                wr = 1'b1; wa = host_address; wd = host_data;
            end
        end else if (!vga_request) begin
            wr = 1'b1; wa = 11'(m_fill_next); wd = m_pattern;
            m_fill_next++;
            if (m_fill_next == 1024) begin
                m_filling = 1'b0; done_exp = 1'b1;
            end
        end
        @(posedge clk); #1;
        if (wr) begin
            model_mem[wa[9:0]] = wd;
            write_count++;
        end
        check("ram_we", ram_write_enable, wr);
        if (wr) begin
            check("ram_addr_wr", ram_address, wa);
            check("ram_wdata", ram_write_data, wd);
        end else if (cur_v) begin
            check("ram_addr_rd", ram_address, vga_address);
        end
        check("fill_busy", fill_busy, m_filling);
        check("fill_done", fill_done, done_exp);
        if (fill_busy) busy_count++;
        if (fill_done) done_count++;
        check("vga_valid", vga_valid, h2_v);
        if (h2_v) check("vga_data", vga_data, h2_d);
        h2_v = h1_v; h2_d = h1_d;
        h1_v = cur_v; h1_d = cur_d;
    endtask

    task automatic idle_inputs();
        vga_request = 1'b0; host_valid = 1'b0; fill_start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ram_addr"}, ram_address, 11'd0);
        check({tag, "_ram_wdata"}, ram_write_data, 8'd0);
        check({tag, "_ram_we"}, ram_write_enable, 1'b0);
        check({tag, "_vga_data"}, vga_data, 8'd0);
        check({tag, "_vga_valid"}, vga_valid, 1'b0);
        check({tag, "_fill_busy"}, fill_busy, 1'b0);
        check({tag, "_fill_done"}, fill_done, 1'b0);
        check({tag, "_host_ready"}, host_ready, 1'b0);
    endtask

    task automatic clear_counts();
        write_count = 0; busy_count = 0; done_count = 0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) model_mem[i] = 8'(i) ^ 8'hA5;
        m_filling = 1'b0; m_fill_next = 0; m_pattern = '0;
        h1_v = 1'b0; h2_v = 1'b0; h1_d = '0; h2_d = '0;
        clear_counts();

        // Power-on reset with RAM preload
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        do_preload = 1'b0;
        rst = 1'b0;

        // Eight back-to-back VGA reads of addresses 0..7
        for (int i = 0; i < 8; i++) begin
            vga_request = 1'b1; vga_address = 11'(i);
            tick();
        end
        vga_request = 1'b0;
        repeat (3) tick();

        // Host write held off by three VGA cycles, then accepted
        host_valid = 1'b1; host_address = 11'd5; host_data = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            vga_request = 1'b1; vga_address = 11'(100 + i);
            tick();
        end
        vga_request = 1'b0;
        tick();
        host_valid = 1'b0;
        tick();
        check("host_write_landed", ram_mem[5], 8'hFF);
        repeat (2) tick();

        // Out-of-range host write and VGA read
        host_valid = 1'b1; host_address = 11'd1500; host_data = 8'h77;
        tick();
        host_valid = 1'b0;
        vga_request = 1'b1; vga_address = 11'd1500;
        tick();
        vga_request = 1'b0;
        repeat (3) tick();

        // Reset asserted mid-fill once the counter has reached 300
        fill_pattern = 8'h5A; fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        for (int i = 0; i < 400 && m_fill_next < 300; i++) tick();
        vga_request = 1'b1; vga_address = 11'd10;
        tick();
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_fill");
        idle_inputs();
        m_filling = 1'b0; h1_v = 1'b0; h2_v = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) tick();
        check("no_write_300", ram_mem[300], model_mem[300]);
        check("write_299_kept", ram_mem[299], 8'h5A);

        // Uninterrupted fill of 3C; a second start mid-fill must be ignored
        clear_counts();
        fill_pattern = 8'h3C; fill_start = 1'b1;
        tick();
        for (int i = 0; i < 1100 && m_filling; i++) begin
            fill_start   = (i == 500);
            fill_pattern = (i == 500) ? 8'h99 : 8'h3C;
            tick();
        end
        fill_start = 1'b0;
        repeat (2) tick();
        check("fill3_writes", write_count, 1024);
        check("fill3_busy_cycles", busy_count, 1024);
        check("fill3_done_pulses", done_count, 1);
        check("fill3_last_byte", ram_mem[1023], 8'h3C);

        // Fill interleaved with VGA reads every other cycle
        clear_counts();
        fill_pattern = 8'($urandom); fill_start = 1'b1;
        vga_request = 1'b1; vga_address = 11'($urandom_range(0, 1100));
        tick();
        fill_start = 1'b0;
        for (int i = 0; i < 2200 && m_filling; i++) begin
            vga_request = i[0];
            vga_address = 11'($urandom_range(0, 1100));
            tick();
        end
        vga_request = 1'b0;
        repeat (3) tick();
        check("fill4_writes", write_count, 1024);
        check("fill4_busy_cycles", busy_count, 2047);
        check("fill4_done_pulses", done_count, 1);

        // Randomized traffic on all three requesters
        for (int i = 0; i < 800; i++) begin
            vga_request  = 1'($urandom_range(0, 1));
            vga_address  = 11'($urandom_range(0, 1200));
            host_valid   = 1'($urandom_range(0, 1));
            host_address = 11'($urandom_range(0, 1200));
            host_data    = 8'($urandom);
            fill_start   = ($urandom_range(0, 399) == 0);
            fill_pattern = 8'($urandom);
            tick();
        end
        idle_inputs();
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
